// File: rtl/btn_conditioner_pkg.sv
// rtl/btn_conditioner_pkg.sv - shared constants and width helpers for the button conditioner
package btn_conditioner_pkg;

   localparam int CLK_HZ                = 100_000_000;
   localparam int N_BTN_DEFAULT         = 3;
   localparam int DB_CYCLES_DEFAULT     = CLK_HZ / 100;  // 10 ms
   localparam int REPEAT_DELAY_DEFAULT  = CLK_HZ / 2;
   localparam int REPEAT_PERIOD_DEFAULT = CLK_HZ / 10;

   localparam int BTN_TEMP_STOP   = 0;
   localparam int BTN_COMPLETION  = 1;
   localparam int BTN_CHECK_TOTAL = 2;

   // Bits needed to hold counts 0..n-1; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// rtl/btn_conditioner_if.sv - raw button inputs and conditioned level/pulse outputs
interface btn_conditioner_if
   import btn_conditioner_pkg::*;
#(
   parameter int N_BTN = N_BTN_DEFAULT
);

   logic [N_BTN-1:0] btn_in;
   logic [N_BTN-1:0] btn_level;
   logic [N_BTN-1:0] btn_press;
   logic [N_BTN-1:0] btn_release;

   modport master (output btn_in, input btn_level, input btn_press, input btn_release);
   modport slave  (input btn_in, output btn_level, output btn_press, output btn_release);

endinterface

// File: rtl/btn_debounce_ch.sv
// rtl/btn_debounce_ch.sv - one button: 2-flop sync, debounce, press/release pulses
// Optional hold auto-repeat on btn_press when BTN_HOLD_REPEAT_EN is defined.
module btn_debounce_ch
   import btn_conditioner_pkg::*;
#(
   parameter int DB_CYCLES     = DB_CYCLES_DEFAULT,
   parameter int REPEAT_DELAY  = REPEAT_DELAY_DEFAULT,
   parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEFAULT
) (
   input  logic clk100,
   input  logic rst,
   input  logic btn_in,
   output logic btn_level,
   output logic btn_press,
   output logic btn_release
);

   localparam int            CW       = cnt_width(DB_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

   if (DB_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
      $error("btn_debounce_ch: illegal timing parameters");
   end

   logic          s1;
   logic          s2;
   logic          stable;
   logic [CW-1:0] cnt;
   logic          accept;
   logic          rep_fire;

   assign accept    = (s2 != stable) && (cnt == CNT_LAST);
   assign btn_level = stable;

   always_ff @(posedge clk100 or negedge rst) begin
      if (!rst) begin
         s1          <= 1'b0;
         s2          <= 1'b0;
         stable      <= 1'b0;
         cnt         <= '0;
         btn_press   <= 1'b0;
         btn_release <= 1'b0;
      end else begin
         s1          <= btn_in;
         s2          <= s1;
         // An accepted release outranks a coinciding repeat, so press and release never overlap.
         btn_press   <= accept ? s2 : rep_fire;
         btn_release <= accept & ~s2;
         if (s2 == stable) begin
            cnt <= '0;
         end else if (accept) begin
            stable <= s2;
            cnt    <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

`ifdef BTN_HOLD_REPEAT_EN
   localparam int RW = cnt_width(max2(REPEAT_DELAY, REPEAT_PERIOD));

   logic [RW-1:0] rcnt;
   logic          rep_phase;  // 0 = waiting out the initial delay, 1 = periodic repeats

   assign rep_fire = stable && (rep_phase ? (rcnt == RW'(REPEAT_PERIOD - 1))
                                          : (rcnt == RW'(REPEAT_DELAY - 1)));

   always_ff @(posedge clk100 or negedge rst) begin
      if (!rst) begin
         rcnt      <= '0;
         rep_phase <= 1'b0;
      end else if (!stable || accept) begin
         rcnt      <= '0;
         rep_phase <= 1'b0;
      end else if (rep_fire) begin
         rcnt      <= '0;
         rep_phase <= 1'b1;
      end else begin
         rcnt <= rcnt + 1'b1;
      end
   end
`else
   assign rep_fire = 1'b0;
`endif

endmodule

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - N_BTN independent debounced button channels
// Optional hold auto-repeat on btn_press when BTN_HOLD_REPEAT_EN is defined.
module btn_conditioner
   import btn_conditioner_pkg::*;
#(
   parameter int N_BTN         = N_BTN_DEFAULT,
   parameter int DB_CYCLES     = DB_CYCLES_DEFAULT,
   parameter int REPEAT_DELAY  = REPEAT_DELAY_DEFAULT,
   parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEFAULT
) (
   input  logic              clk100,
   input  logic              rst,
   btn_conditioner_if.slave  bus
);

   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      btn_debounce_ch #(
         .DB_CYCLES     (DB_CYCLES),
         .REPEAT_DELAY  (REPEAT_DELAY),
         .REPEAT_PERIOD (REPEAT_PERIOD)
      ) u_ch (
         .clk100      (clk100),
         .rst         (rst),
         .btn_in      (bus.btn_in[i]),
         .btn_level   (bus.btn_level[i]),
         .btn_press   (bus.btn_press[i]),
         .btn_release (bus.btn_release[i])
      );
   end

endmodule

// File: tb/tb_btn_conditioner.sv
// tb/tb_btn_conditioner.sv - scoreboard bench for btn_conditioner against a sample-window model
module tb_btn_conditioner;
   import btn_conditioner_pkg::*;

   localparam int N    = 3;
   localparam int DB   = 4;
   localparam int RD   = 10;
   localparam int RP   = 3;
   localparam int HMAX = 8192;

   typedef struct {
      int           cyc;
      logic [N-1:0] press;
      logic [N-1:0] rel;
   } ev_t;

   logic clk100 = 1'b0;
   logic rst    = 1'b0;
   always #5 clk100 = ~clk100;

   btn_conditioner_if #(.N_BTN(N)) bus ();

   btn_conditioner #(
      .N_BTN         (N),
      .DB_CYCLES     (DB),
      .REPEAT_DELAY  (RD),
      .REPEAT_PERIOD (RP)
   ) dut (
      .clk100 (clk100),
      .rst    (rst),
      .bus    (bus)
   );

   int checks   = 0;
   int failures = 0;

   ev_t          q[$];
   logic [N-1:0] hist [HMAX];
   logic [N-1:0] mlevel = '0;
   int           acc_cyc [N];
   int           cyc = 0;

   int press_cnt  [N];
   int rel_cnt    [N];
   int last_press [N];
   int lvl_hits   [N];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Level flips at edge e when the DB samples taken at edges e-DB-1 .. e-2 all disagree with it.
   function automatic logic window_flips(input int e, input int ch, input logic lvl);
      for (int j = e - DB - 1; j <= e - 2; j++) begin
         if (j < 0) return 1'b0;
         if (hist[j][ch] == lvl) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic model_step();
      ev_t ev;
      cyc++;
      if (cyc >= HMAX) return;
      if (!rst) begin
         hist[cyc]   = '0;
         hist[cyc-1] = '0;
         mlevel      = '0;
      end else begin
         hist[cyc] = bus.btn_in;
         ev.cyc    = cyc;
         ev.press  = '0;
         ev.rel    = '0;
         for (int ch = 0; ch < N; ch++) begin
            if (window_flips(cyc, ch, mlevel[ch])) begin
               mlevel[ch] = ~mlevel[ch];
               if (mlevel[ch]) begin
                  ev.press[ch] = 1'b1;
                  acc_cyc[ch]  = cyc;
               end else begin
                  ev.rel[ch] = 1'b1;
               end
            end
`ifdef BTN_HOLD_REPEAT_EN
            else if (mlevel[ch] && (cyc - acc_cyc[ch]) >= RD
                     && ((cyc - acc_cyc[ch] - RD) % RP) == 0) begin
               ev.press[ch] = 1'b1;
            end
`endif
         end
         if ((ev.press | ev.rel) != '0) q.push_back(ev);
      end
   endtask

   task automatic monitor_step();
      while (q.size() > 0 && q[0].cyc < cyc) begin
         check("missing_pulse_at_cycle", 0, q[0].cyc);
         void'(q.pop_front());
      end
      if (!rst) begin
         check("reset_outputs_zero", int'({bus.btn_level, bus.btn_press, bus.btn_release}), 0);
      end else begin
         check("level", int'(bus.btn_level), int'(mlevel));
         check("press_and_release_overlap", int'(bus.btn_press & bus.btn_release), 0);
         for (int ch = 0; ch < N; ch++) begin
            if (bus.btn_press[ch]) begin
               press_cnt[ch]++;
               last_press[ch] = cyc;
            end
            if (bus.btn_release[ch]) rel_cnt[ch]++;
            if (bus.btn_level[ch])   lvl_hits[ch]++;
         end
         if ((bus.btn_press | bus.btn_release) != '0) begin
            if (q.size() > 0 && q[0].cyc == cyc) begin
               check("press_vector", int'(bus.btn_press), int'(q[0].press));
               check("release_vector", int'(bus.btn_release), int'(q[0].rel));
               void'(q.pop_front());
            end else begin
               check("unexpected_pulse", int'({bus.btn_press, bus.btn_release}), 0);
            end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < HMAX; i++) hist[i] = '0;
      for (int ch = 0; ch < N; ch++) begin
         acc_cyc[ch] = 0; press_cnt[ch] = 0; rel_cnt[ch] = 0;
         last_press[ch] = -1; lvl_hits[ch] = 0;
      end
   end

   initial forever begin
      @(posedge clk100);
      model_step();
   end

   initial forever begin
      @(negedge clk100);
      monitor_step();
   end

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk100);
         #1;
      end
   endtask

   initial begin
      int c;
      int p0;
      int r0;
      int h0;
      int rem [N];
      logic [N-1:0] v;

      // Reset held with all buttons pressed, then released.
      bus.btn_in = '1;
      step(5);
      c   = cyc;
      rst = 1'b1;
      step(8);
      check("held_through_reset_press_cycle", last_press[BTN_TEMP_STOP], c + DB + 2);
      check("held_through_reset_press_count", press_cnt[0] + press_cnt[1] + press_cnt[2], 3);

      bus.btn_in = '0;
      step(10);
      check("release_all_count", rel_cnt[0] + rel_cnt[1] + rel_cnt[2], 3);

      // Clean press on channel 0.
      c  = cyc;
      p0 = press_cnt[1] + press_cnt[2];
      bus.btn_in[BTN_TEMP_STOP] = 1'b1;
      step(8);
      check("clean_press_latency", last_press[0], c + DB + 2);
      check("clean_press_other_channels", press_cnt[1] + press_cnt[2], p0);

      // Three-cycle glitch on channel 1.
      p0 = press_cnt[1]; r0 = rel_cnt[1]; h0 = lvl_hits[1];
      bus.btn_in[BTN_COMPLETION] = 1'b1;
      step(DB - 1);
      bus.btn_in[BTN_COMPLETION] = 1'b0;
      step(10);
      check("glitch_no_press", press_cnt[1], p0);
      check("glitch_no_release", rel_cnt[1], r0);
      check("glitch_no_level", lvl_hits[1], h0);

      // Bouncing press on channel 2, then a steady release.
      p0 = press_cnt[2]; r0 = rel_cnt[2];
      v = 6'b101101;
      for (int i = 5; i >= 0; i--) begin
         bus.btn_in[BTN_CHECK_TOTAL] = v[i];
         c = cyc;
         step(1);
      end
      step(7);
      check("bounce_single_press", press_cnt[2] - p0, 1);
      check("bounce_press_latency", last_press[2], c + DB + 2);
      bus.btn_in[BTN_CHECK_TOTAL] = 1'b0;
      step(10);
      check("bounce_single_release", rel_cnt[2] - r0, 1);

      // Async reset mid-count on channel 0.
      bus.btn_in[BTN_TEMP_STOP] = 1'b0;
      step(10);
      p0 = press_cnt[0];
      c  = cyc;
      bus.btn_in[BTN_TEMP_STOP] = 1'b1;
      step(2);
      rst = 1'b0;
      step(1);
      rst = 1'b1;
      step(8);
      check("reset_mid_count_press_count", press_cnt[0] - p0, 1);
      check("reset_mid_count_latency", last_press[0], c + 9);

      // Long hold on channel 0 (exercises auto-repeat when enabled), then release.
      p0 = press_cnt[0]; r0 = rel_cnt[0];
      step(30);
`ifdef BTN_HOLD_REPEAT_EN
      check("hold_repeat_count", press_cnt[0] - p0, 8);
`else
      check("hold_no_repeat", press_cnt[0] - p0, 0);
`endif
      bus.btn_in[BTN_TEMP_STOP] = 1'b0;
      p0 = press_cnt[0];
      step(15);
      check("hold_release_count", rel_cnt[0] - r0, 1);
      check("no_press_after_release", press_cnt[0] - p0, 0);

      // Randomised activity with occasional resets.
      for (int ch = 0; ch < N; ch++) rem[ch] = $urandom_range(0, 20);
      for (int t = 0; t < 2500; t++) begin
         v = bus.btn_in;
         for (int ch = 0; ch < N; ch++) begin
            if (rem[ch] == 0) begin
               v[ch]   = ~v[ch];
               rem[ch] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, DB - 1))
                                                     : int'($urandom_range(DB, 4 * RD));
            end else begin
               rem[ch]--;
            end
         end
         bus.btn_in = v;
         if ($urandom_range(0, 399) == 0) begin
            rst = 1'b0;
            step($urandom_range(1, 2));
            rst = 1'b1;
         end
         step(1);
      end

      bus.btn_in = '0;
      step(2 * RD + DB + 10);
      check("scoreboard_drained", q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      failures++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

endmodule
